// File: rtl/lp_mult_result_accum.sv
// lp_mult_result_accum: captures products from a multiplier pipe in a small
// FIFO, sums groups of n_terms products and presents each group sum with the
// ID of its last product until downstream takes it.
module lp_mult_result_accum #(
    parameter int prod_width = 16,
    parameter int id_width   = 8,
    parameter int acc_width  = 24,
    parameter int depth      = 4,
    parameter int tc_mode    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           arrive,
    input  logic [id_width-1:0]            arrive_id,
    input  logic [prod_width-1:0]          product,
    output logic                           accept_n,
    input  logic [3:0]                     n_terms,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [acc_width-1:0]           result,
    output logic [id_width-1:0]            result_id,
    output logic [$clog2(depth+1)-1:0]     fifo_census,
    output logic                           ovf_err
);

    localparam int cw = $clog2(depth + 1);
    localparam int aw = $clog2(depth);

    typedef struct packed {
        logic [id_width-1:0]   id;
        logic [prod_width-1:0] prod;
    } entry_t;

    typedef enum logic {ACC, OUT} state_t;

    entry_t              mem [depth];
    logic [aw-1:0]       wr_ptr, rd_ptr;
    logic [cw-1:0]       cnt;
    state_t              state, state_nxt;
    logic [acc_width-1:0] acc, acc_sum, ext;
    logic [3:0]          term_cnt, grp_len, new_len, eff_len;
    logic                push, pop, last;
    entry_t              head;

    // Full is judged on the registered count only, so accept_n never
    // depends on this cycle's pop.
    assign accept_n    = (cnt == cw'(depth));
    assign push        = arrive && !accept_n;
    assign fifo_census = cnt;
    assign head        = mem[rd_ptr];

    // Group length is latched on the first pop of a group; 0 means 1.
    assign new_len = (n_terms == 4'd0) ? 4'd1 : n_terms;
    assign eff_len = (term_cnt == 4'd0) ? new_len : grp_len;
    assign last    = (term_cnt == eff_len - 4'd1);

    // Product extension: zero- or sign-extend to the accumulator width.
    always_comb begin
        if (tc_mode != 0) ext = acc_width'($signed(head.prod));
        else              ext = acc_width'(head.prod);
    end

    assign acc_sum = acc + ext;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    // Next state and pop decision: pop the head every ACC cycle it exists.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ACC: begin
                if (cnt != '0) begin
                    pop = 1'b1;
                    if (last) state_nxt = OUT;
                end
            end
            OUT: begin
                if (result_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    // FIFO storage; arrivals during reset are never written.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= '{id: arrive_id, prod: product};
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (arrive && accept_n) ovf_err <= 1'b1;
        end
    end

    // Accumulator, term counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc          <= '0;
            term_cnt     <= '0;
            grp_len      <= 4'd1;
            result_valid <= 1'b0;
            result       <= '0;
            result_id    <= '0;
        end else if (pop) begin
            acc      <= acc_sum;
            term_cnt <= term_cnt + 4'd1;
            if (term_cnt == 4'd0) grp_len <= new_len;
            if (last) begin
                result       <= acc_sum;
                result_id    <= head.id;
                result_valid <= 1'b1;
            end
        end else if (state == OUT && result_ready) begin
            result_valid <= 1'b0;
            acc          <= '0;
            term_cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_lp_mult_result_accum.sv
// tb_lp_mult_result_accum: three instances (unsigned/24b, signed/24b,
// unsigned/16b) share one stimulus stream and are compared every cycle
// against a queue-based reference model, plus a few fixed-value checks.
module tb_lp_mult_result_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arr;
    logic [7:0]  aid;
    logic [15:0] prod;
    logic [3:0]  nt;
    logic        rdy;

    logic        acc_n [3];
    logic        rv    [3];
    logic [7:0]  rid   [3];
    logic [2:0]  cen   [3];
    logic        ovf   [3];
    logic [23:0] res0, res1;
    logic [15:0] res2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lp_mult_result_accum #(.prod_width(16), .id_width(8), .acc_width(24), .depth(4), .tc_mode(0)) d0 (
        .clk(clk), .rst_n(rst_n), .arrive(arr), .arrive_id(aid), .product(prod),
        .accept_n(acc_n[0]), .n_terms(nt), .result_valid(rv[0]), .result_ready(rdy),
        .result(res0), .result_id(rid[0]), .fifo_census(cen[0]), .ovf_err(ovf[0]));

    lp_mult_result_accum #(.prod_width(16), .id_width(8), .acc_width(24), .depth(4), .tc_mode(1)) d1 (
        .clk(clk), .rst_n(rst_n), .arrive(arr), .arrive_id(aid), .product(prod),
        .accept_n(acc_n[1]), .n_terms(nt), .result_valid(rv[1]), .result_ready(rdy),
        .result(res1), .result_id(rid[1]), .fifo_census(cen[1]), .ovf_err(ovf[1]));

    lp_mult_result_accum #(.prod_width(16), .id_width(8), .acc_width(16), .depth(4), .tc_mode(0)) d2 (
        .clk(clk), .rst_n(rst_n), .arrive(arr), .arrive_id(aid), .product(prod),
        .accept_n(acc_n[2]), .n_terms(nt), .result_valid(rv[2]), .result_ready(rdy),
        .result(res2), .result_id(rid[2]), .fifo_census(cen[2]), .ovf_err(ovf[2]));

    // reference model state
    typedef struct {
        logic [7:0]  id;
        logic [15:0] p;
    } ent_t;

    ent_t        q[$];
    bit          m_out;
    int          m_terms, m_len;
    logic [63:0] macc [3];
    logic [63:0] mres [3];
    logic [7:0]  m_rid;
    bit          m_rv, m_ovf;

    function automatic logic [63:0] mask(input int i);
        return (i == 2) ? 64'hFFFF : 64'hFF_FFFF;
    endfunction

    function automatic logic [63:0] ext(input logic [15:0] p, input bit sgn);
        if (sgn && p[15]) return {48'hFFFF_FFFF_FFFF, p};
        return {48'h0, p};
    endfunction

    function automatic logic [63:0] dut_res(input int i);
        case (i)
            0:       return {40'h0, res0};
            1:       return {40'h0, res1};
            default: return {48'h0, res2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One clock of the reference behaviour, using the inputs held this cycle.
    task automatic model_step();
        bit   full, do_pop;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_out = 0; m_terms = 0; m_len = 1;
            for (int i = 0; i < 3; i++) begin macc[i] = 0; mres[i] = 0; end
            m_rid = 0; m_rv = 0; m_ovf = 0;
            return;
        end
        full   = (q.size() == 4);
        do_pop = !m_out && (q.size() > 0);
        if (m_out) begin
            if (rdy) begin m_out = 0; m_rv = 0; end
        end else if (do_pop) begin
            e = q.pop_front();
            if (m_terms == 0) m_len = (nt == 0) ? 1 : int'(nt);
            for (int i = 0; i < 3; i++) macc[i] = (macc[i] + ext(e.p, i == 1)) & mask(i);
            m_terms++;
            if (m_terms == m_len) begin
                for (int i = 0; i < 3; i++) begin mres[i] = macc[i]; macc[i] = 0; end
                m_rid = e.id; m_rv = 1; m_out = 1; m_terms = 0;
            end
        end
        if (arr) begin
            if (full) m_ovf = 1;
            else      q.push_back('{id: aid, p: prod});
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_valid", i),  {63'h0, rv[i]},    {63'h0, m_rv});
            chk($sformatf("d%0d_result", i), dut_res(i),        mres[i]);
            chk($sformatf("d%0d_id", i),     {56'h0, rid[i]},   {56'h0, m_rid});
            chk($sformatf("d%0d_census", i), {61'h0, cen[i]},   64'(q.size()));
            chk($sformatf("d%0d_accept_n", i), {63'h0, acc_n[i]}, {63'h0, q.size() == 4});
            chk($sformatf("d%0d_ovf", i),    {63'h0, ovf[i]},   {63'h0, m_ovf});
        end
    endtask

    // Called at a negedge: apply inputs, clock once, check after the edge.
    task automatic cyc(input logic r, input logic a, input logic [7:0] i,
                       input logic [15:0] p, input logic [3:0] n, input logic rd);
        rst_n = r; arr = a; aid = i; prod = p; nt = n; rdy = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 0; arr = 0; aid = 0; prod = 0; nt = 0; rdy = 0;
        @(negedge clk);
        cyc(0, 1, 8'h11, 16'h1234, 4'd1, 0);
        cyc(0, 0, 0, 0, 4'd1, 0);
        chk("rst_census", {61'h0, cen[0]}, 64'd0);
        chk("rst_accept_n", {63'h0, acc_n[0]}, 64'd0);

        // three-term unsigned group, 5+7+9
        cyc(1, 1, 8'd1, 16'd5, 4'd3, 1);
        cyc(1, 1, 8'd2, 16'd7, 4'd3, 1);
        cyc(1, 1, 8'd3, 16'd9, 4'd3, 1);
        cyc(1, 0, 0, 0, 4'd3, 1);
        chk("g3_valid", {63'h0, rv[0]}, 64'd1);
        chk("g3_result", {40'h0, res0}, 64'd21);
        chk("g3_id", {56'h0, rid[0]}, 64'd3);
        cyc(1, 0, 0, 0, 4'd3, 1);
        chk("g3_valid_one_cycle", {63'h0, rv[0]}, 64'd0);

        // signed pair -2 + 1, then unsigned wrap 0xFFFF + 0xFFFF in 16 bits
        cyc(1, 1, 8'd4, 16'hFFFE, 4'd2, 1);
        cyc(1, 1, 8'd5, 16'h0001, 4'd2, 1);
        cyc(1, 0, 0, 0, 4'd2, 1);
        chk("tc_result", {40'h0, res1}, 64'hFF_FFFF);
        cyc(1, 0, 0, 0, 4'd2, 1);
        cyc(1, 1, 8'd6, 16'hFFFF, 4'd2, 1);
        cyc(1, 1, 8'd7, 16'hFFFF, 4'd2, 1);
        cyc(1, 0, 0, 0, 4'd2, 1);
        chk("wrap_result", {48'h0, res2}, 64'hFFFE);
        cyc(1, 0, 0, 0, 4'd2, 1);

        // held result, FIFO fills, sixth arrival dropped
        for (int k = 0; k < 6; k++) cyc(1, 1, 8'(8'h20 + k), 16'(100 + k), 4'd1, 0);
        chk("full_census", {61'h0, cen[0]}, 64'd4);
        chk("full_accept_n", {63'h0, acc_n[0]}, 64'd1);
        chk("full_ovf", {63'h0, ovf[0]}, 64'd1);
        chk("full_held", {40'h0, res0}, 64'd100);

        // drain from full with a four-term group
        for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 4'd4, 1);

        // reset mid-group, arrival in reset cycle dropped without overflow
        cyc(1, 1, 8'd9, 16'd50, 4'd3, 1);
        cyc(1, 0, 0, 0, 4'd3, 1);
        cyc(0, 1, 8'd8, 16'd70, 4'd3, 1);
        chk("mid_rst_ovf", {63'h0, ovf[0]}, 64'd0);
        chk("mid_rst_result", {40'h0, res0}, 64'd0);
        cyc(1, 1, 8'd10, 16'd1, 4'd3, 1);
        cyc(1, 1, 8'd11, 16'd2, 4'd3, 1);
        cyc(1, 1, 8'd12, 16'd3, 4'd3, 1);
        cyc(1, 0, 0, 0, 4'd3, 1);
        chk("post_rst_result", {40'h0, res0}, 64'd6);
        chk("post_rst_id", {56'h0, rid[0]}, 64'd12);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] n;
            n = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 99) < 60),
                8'($urandom),
                16'($urandom),
                n,
                ($urandom_range(0, 99) < 50));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
